csr_stream_writer: RTL and testbench
====================================

Name: csr_stream_writer

Overview:
- Write-side counterpart to the HHT sparse-matrix `control` fetch path.
- Accepts a dense matrix streamed row-major and compresses it into the CSR memory image that `control` reads:
  - row pointers at row_base,
  - column indices at wdata_col_base,
  - nonzero values at matrix_base.
- Port 1 writes the index memory (row pointers and column indices, same address space as addr1). Port 2 writes the value memory (same space as addr2).

Parameters:
N_ROWS, 16, matrix rows; number of row-pointer entries written = N_ROWS+1
N_COLS, 16, matrix columns; elements per row accepted on the input stream
DW, 32, data and address width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a matrix when idle
row_base  in  DW  base address of the row-pointer array
wdata_col_base  in  DW  base address of the column-index array
matrix_base  in  DW  base address of the value array
in_valid  in  1  dense element present on in_data
in_data  in  DW  dense element, row-major order
in_ready  out  1  writer can accept in_data this cycle
wr1_en  out  1  index-memory write strobe
wr1_addr  out  DW  index-memory address
wr1_data  out  DW  row pointer or column index
wr2_en  out  1  value-memory write strobe
wr2_addr  out  DW  value-memory address
wr2_data  out  DW  nonzero value
busy  out  1  matrix in progress
done  out  1  one-cycle pulse; matrix fully written
nnz  out  DW  running nonzero count; holds final count after done

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; all outputs 0; row, col and nnz counters cleared.
  - Reset mid-matrix aborts the matrix; partial memory contents are don't-care.
- All write outputs are registered. A write decided in cycle k is presented (en, addr, data) in cycle k+1 for exactly one cycle.
- At most one write per port per cycle.
- IDLE: in_ready=0, busy=0.
  - On start=1: latch the three bases, clear counters, go to PTR0. busy=1 from the next cycle.
- PTR0 (1 cycle): issue wr1 at row_base, data 0. Go to STREAM.
- STREAM: in_ready=1. Each handshake (in_valid & in_ready) at column c:
  - If in_data != 0:
    - wr1 at wdata_col_base+nnz, data c;
    - wr2 at matrix_base+nnz, data in_data;
    - nnz += 1.
  - If in_data == 0: no write. The element is still consumed.
  - If c == N_COLS-1: go to ROWEND; otherwise c += 1.
  - in_valid=0: hold; no state change; no writes.
- ROWEND (1 cycle): in_ready=0.
  - Issue wr1 at row_base+row+1, data nnz (nnz already includes this row's last element).
  - col=0.
  - If row == N_ROWS-1: go to FIN; otherwise row += 1 and go to STREAM.
  - This stall guarantees the last column-index write and the row-pointer write never share port 1 in the same cycle.
- FIN (1 cycle): done=1 in the cycle after FIN is entered. busy drops in that same cycle. Return to IDLE.
- start while busy: ignored. start in the same cycle done is asserted: ignored; a new start is accepted only in IDLE.
- All-zero row: its row pointer equals the previous one. An all-zero matrix yields N_ROWS+1 row-pointer writes of 0 and no wr2 writes.
- Arithmetic: addresses are base + offset, modulo 2^DW with no overflow check. nnz max is N_ROWS*N_COLS.
- Row-pointer writes are monotonically non-decreasing. The final row pointer equals the final nnz.
- Cycle count with no input gaps: 1 (PTR0) + N_ROWS*(N_COLS+1) + 1 (FIN), measured from start accepted to done.

Test Plan:
- N_ROWS=N_COLS=4, identity matrix (value 5 on the diagonal), bases 34300/3200/90:
  - row pointers 0,1,2,3,4 at 34300..34304;
  - column indices 0,1,2,3 at 3200..3203;
  - values 5,5,5,5 at 90..93;
  - nnz=4; done exactly 22 cycles after start.
- All-zero 4x4: five wr1 writes of 0 at 34300..34304, no wr2 activity, nnz=0.
- Fully dense 4x4 with values 1..16:
  - row pointers 0,4,8,12,16;
  - column indices repeat 0,1,2,3;
  - values 1..16 at 90..105;
  - in_ready low for one cycle after every fourth handshake.
- Default 16x16 with row 0 holding 14 nonzeros (cols 0-14 except 4) and row 1 holding 15 nonzeros (all except col 12): row_base+1=14, row_base+2=29, and column indices at 3200..3213 match the skipped positions. Insert random in_valid gaps; results must be identical.
- Assert Rst low mid-row 2, then release and restart with the 4x4 identity case:
  - outputs 0 while in reset;
  - second run produces exactly the identity-case results.
- Pulse start while busy and again in the done cycle: ignored, with no counter reset and no second matrix. A start in IDLE afterwards begins normally.

Source files
------------

// File: rtl/csr_stream_writer.sv
// -----------------------------------------------------------------------------
// csr_stream_writer
//
// Compresses a dense matrix, streamed in row-major order, into the CSR memory
// image read by the sparse-matrix `control` fetch path:
//   - row pointers  (N_ROWS+1 words) at row_base        -> port 1
//   - column indices (one per nonzero) at wdata_col_base -> port 1
//   - nonzero values (one per nonzero) at matrix_base    -> port 2
//
// Ports:
//   Clk, Rst                 clock (rising edge), asynchronous active-low reset
//   start                    one-cycle pulse, begins a matrix when idle
//   row_base, wdata_col_base, matrix_base
//                            array base addresses, latched on start
//   in_valid/in_data/in_ready  dense element stream
//   wr1_en/wr1_addr/wr1_data   index-memory write (row pointer or column index)
//   wr2_en/wr2_addr/wr2_data   value-memory write (nonzero value)
//   busy                     matrix in progress
//   done                     one-cycle pulse, matrix fully written
//   nnz                      running nonzero count, holds final count after done
//
// Handshake: an element transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the FSM state (never on in_valid),
// the producer may raise or drop in_valid freely, and in_data only matters in
// a transfer cycle.
//
// Every write is registered: a write decided in cycle k appears on the port
// (en, addr, data) during cycle k+1 for exactly one cycle.
// -----------------------------------------------------------------------------
module csr_stream_writer #(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int DW     = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [DW-1:0] row_base,
  input  logic [DW-1:0] wdata_col_base,
  input  logic [DW-1:0] matrix_base,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr1_en,
  output logic [DW-1:0] wr1_addr,
  output logic [DW-1:0] wr1_data,
  output logic          wr2_en,
  output logic [DW-1:0] wr2_addr,
  output logic [DW-1:0] wr2_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] nnz
);

  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [DW-1:0] ONE      = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PTR0   = 3'd1,
    S_STREAM = 3'd2,
    S_ROWEND = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] row_base_q;
  logic [DW-1:0] col_base_q;
  logic [DW-1:0] val_base_q;
  logic          take;
  logic          last_col;
  logic          last_row;

  assign in_ready = (state == S_STREAM);
  assign take     = in_valid && (state == S_STREAM);
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_PTR0;
      S_PTR0:   state_next = S_STREAM;
      S_STREAM: if (take && last_col) state_next = S_ROWEND;
      S_ROWEND: state_next = last_row ? S_FIN : S_STREAM;
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: counters, latched bases and registered write ports.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col        <= '0;
      row        <= '0;
      nnz        <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      val_base_q <= '0;
      wr1_en     <= 1'b0;
      wr1_addr   <= '0;
      wr1_data   <= '0;
      wr2_en     <= 1'b0;
      wr2_addr   <= '0;
      wr2_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Strobes are single-cycle by default; address/data simply hold.
      wr1_en <= 1'b0;
      wr2_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row_base_q <= row_base;
            col_base_q <= wdata_col_base;
            val_base_q <= matrix_base;
            col        <= '0;
            row        <= '0;
            nnz        <= '0;
            busy       <= 1'b1;
          end
        end
        S_PTR0: begin
          // Row pointer 0 is always zero.
          wr1_en   <= 1'b1;
          wr1_addr <= row_base_q;
          wr1_data <= '0;
        end
        S_STREAM: begin
          if (take) begin
            if (in_data != '0) begin
              // nnz before increment is this element's slot in both arrays.
              wr1_en   <= 1'b1;
              wr1_addr <= col_base_q + nnz;
              wr1_data <= DW'(col);
              wr2_en   <= 1'b1;
              wr2_addr <= val_base_q + nnz;
              wr2_data <= in_data;
              nnz      <= nnz + ONE;
            end
            if (!last_col) begin
              col <= col + CW'(1);
            end
          end
        end
        S_ROWEND: begin
          // Port 1 is free here: the last column-index write of the row was
          // issued in the previous cycle, and nnz already counts it.
          wr1_en   <= 1'b1;
          wr1_addr <= row_base_q + DW'(row) + ONE;
          wr1_data <= nnz;
          col      <= '0;
          if (last_row) begin
            // busy drops and done rises together, in the cycle spent in FIN.
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end
        S_FIN: begin
          // Single cycle; start is not accepted here.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_stream_writer.sv
// -----------------------------------------------------------------------------
// Testbench for csr_stream_writer: a 4x4 instance driven from a table of
// hand-computed vectors, and a default 16x16 instance for the two-row case.
// Both instances share the stream/base inputs; `sel` steers start and picks
// which instance's outputs are observed.
// -----------------------------------------------------------------------------
module tb_csr_stream_writer;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sel;
  logic          start_d;
  logic [DW-1:0] rb, cb, mb;
  logic          in_valid;
  logic [DW-1:0] in_data;

  logic          start4, start16;
  logic          in_ready4, wr1_en4, wr2_en4, busy4, done4;
  logic [DW-1:0] wr1_addr4, wr1_data4, wr2_addr4, wr2_data4, nnz4;
  logic          in_ready16, wr1_en16, wr2_en16, busy16, done16;
  logic [DW-1:0] wr1_addr16, wr1_data16, wr2_addr16, wr2_data16, nnz16;

  assign start4  = start_d & ~sel;
  assign start16 = start_d & sel;

  csr_stream_writer #(.N_ROWS(4), .N_COLS(4), .DW(DW)) dut4 (
    .Clk(clk), .Rst(rst_n), .start(start4),
    .row_base(rb), .wdata_col_base(cb), .matrix_base(mb),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .wr1_en(wr1_en4), .wr1_addr(wr1_addr4), .wr1_data(wr1_data4),
    .wr2_en(wr2_en4), .wr2_addr(wr2_addr4), .wr2_data(wr2_data4),
    .busy(busy4), .done(done4), .nnz(nnz4)
  );

  csr_stream_writer dut16 (
    .Clk(clk), .Rst(rst_n), .start(start16),
    .row_base(rb), .wdata_col_base(cb), .matrix_base(mb),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready16),
    .wr1_en(wr1_en16), .wr1_addr(wr1_addr16), .wr1_data(wr1_data16),
    .wr2_en(wr2_en16), .wr2_addr(wr2_addr16), .wr2_data(wr2_data16),
    .busy(busy16), .done(done16), .nnz(nnz16)
  );

  logic          in_ready_s, wr1_en_s, wr2_en_s, busy_s, done_s;
  logic [DW-1:0] wr1_addr_s, wr1_data_s, wr2_addr_s, wr2_data_s, nnz_s;
  assign in_ready_s = sel ? in_ready16 : in_ready4;
  assign wr1_en_s   = sel ? wr1_en16   : wr1_en4;
  assign wr1_addr_s = sel ? wr1_addr16 : wr1_addr4;
  assign wr1_data_s = sel ? wr1_data16 : wr1_data4;
  assign wr2_en_s   = sel ? wr2_en16   : wr2_en4;
  assign wr2_addr_s = sel ? wr2_addr16 : wr2_addr4;
  assign wr2_data_s = sel ? wr2_data16 : wr2_data4;
  assign busy_s     = sel ? busy16     : busy4;
  assign done_s     = sel ? done16     : done4;
  assign nnz_s      = sel ? nnz16      : nnz4;

  // ---------------- scoreboard ----------------
  logic [2*DW-1:0] exp1_q[$], exp2_q[$], act1_q[$], act2_q[$];
  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mat[256];
  int            exp_rp[17];
  logic [DW-1:0] exp_col[256];
  logic [DW-1:0] exp_val[256];
  int            exp_nz;

  // Capture every write seen on the selected instance.
  always @(negedge clk) begin
    if (wr1_en_s) act1_q.push_back({wr1_addr_s, wr1_data_s});
    if (wr2_en_s) act2_q.push_back({wr2_addr_s, wr2_data_s});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected port-1 order: pointer 0, then per row its column indices
  // followed by that row's closing pointer. Port 2 is the value list.
  task automatic build_expected(input int nr);
    exp1_q.delete();
    exp2_q.delete();
    exp1_q.push_back({rb, DW'(exp_rp[0])});
    for (int r = 0; r < nr; r++) begin
      for (int j = exp_rp[r]; j < exp_rp[r+1]; j++)
        exp1_q.push_back({cb + DW'(j), exp_col[j]});
      exp1_q.push_back({rb + DW'(r + 1), DW'(exp_rp[r+1])});
    end
    for (int j = 0; j < exp_nz; j++)
      exp2_q.push_back({mb + DW'(j), exp_val[j]});
  endtask

  task automatic compare_writes(input string tag);
    int n1, n2;
    check({tag, "_wr1_count"}, 64'(act1_q.size()), 64'(exp1_q.size()));
    check({tag, "_wr2_count"}, 64'(act2_q.size()), 64'(exp2_q.size()));
    n1 = (act1_q.size() < exp1_q.size()) ? act1_q.size() : exp1_q.size();
    n2 = (act2_q.size() < exp2_q.size()) ? act2_q.size() : exp2_q.size();
    for (int i = 0; i < n1; i++)
      check($sformatf("%s_wr1[%0d]", tag, i), act1_q[i], exp1_q[i]);
    for (int i = 0; i < n2; i++)
      check($sformatf("%s_wr2[%0d]", tag, i), act2_q[i], exp2_q[i]);
    check({tag, "_nnz"}, 64'(nnz_s), 64'(exp_nz));
    act1_q.delete();
    act2_q.delete();
  endtask

  // ---------------- drivers ----------------
  // Feeds mat[0..n-1]; with gaps, in_valid randomly idles for a cycle.
  task automatic feed(input int n, input bit gaps);
    int  i = 0;
    int  guard = 0;
    int  ncols;
    bit  hs;
    ncols = sel ? 16 : 4;
    while (i < n && guard < 5000) begin
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = mat[i];
      end
      @(negedge clk);
      hs = in_valid && in_ready_s;
      @(posedge clk);
      #1;
      if (hs) begin
        if ((i % ncols) == ncols - 1)
          check("ready_low_after_row", 64'(in_ready_s), 64'd0);
        i++;
      end
    end
    in_valid = 1'b0;
    check("feed_complete", 64'(i), 64'(n));
  endtask

  // Full matrix run; poke pulses start mid-run and again in the done cycle.
  task automatic run_matrix(input int n, input int exp_cycles, input bit gaps, input bit poke);
    int cnt = 0;
    bit got = 1'b0;
    @(posedge clk);
    #1;
    start_d = 1'b1;
    fork
      feed(n, gaps);
      begin
        while (!got && cnt < 3000) begin
          @(posedge clk);
          #1;
          cnt++;
          start_d = 1'b0;
          if (cnt == 1) check("busy_after_start", 64'(busy_s), 64'd1);
          if (poke && cnt == 8) start_d = 1'b1;
          if (done_s) begin
            got = 1'b1;
            if (poke) start_d = 1'b1;
          end
        end
        check("done_seen", 64'(got), 64'd1);
        if (!gaps) check("start_to_done_cycles", 64'(cnt), 64'(exp_cycles));
        check("busy_low_with_done", 64'(busy_s), 64'd0);
        @(posedge clk);
        #1;
        start_d = 1'b0;
        check("done_one_cycle", 64'(done_s), 64'd0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_done", 64'(busy_s), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [0:15][7:0] m;
    logic [0:4][7:0]  rp;
    logic [7:0]       nz;
    logic [0:15][7:0] col;
    logic [0:15][7:0] val;
  } vec_t;

  vec_t vecs[4];

  task automatic load_vec(input int v);
    for (int j = 0; j < 16; j++) begin
      mat[j]     = DW'(vecs[v].m[j]);
      exp_col[j] = DW'(vecs[v].col[j]);
      exp_val[j] = DW'(vecs[v].val[j]);
    end
    for (int r = 0; r < 5; r++) exp_rp[r] = int'(vecs[v].rp[r]);
    exp_nz = int'(vecs[v].nz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready4), 64'd0);
    check({tag, "_busy"},     64'(busy4),     64'd0);
    check({tag, "_done"},     64'(done4),     64'd0);
    check({tag, "_wr1"},      64'({wr1_en4, wr1_addr4, wr1_data4}), 64'd0);
    check({tag, "_wr2"},      64'({wr2_en4, wr2_addr4, wr2_data4}), 64'd0);
    check({tag, "_nnz"},      64'(nnz4),      64'd0);
    check({tag, "_busy16"},   64'(busy16),    64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; sel = 1'b0; start_d = 1'b0;
    in_valid = 1'b0; in_data = '0;
    rb = 32'd34300; cb = 32'd3200; mb = 32'd90;

    // identity, value 5 on the diagonal
    vecs[0].m   = {8'd5,8'd0,8'd0,8'd0, 8'd0,8'd5,8'd0,8'd0, 8'd0,8'd0,8'd5,8'd0, 8'd0,8'd0,8'd0,8'd5};
    vecs[0].rp  = {8'd0,8'd1,8'd2,8'd3,8'd4};
    vecs[0].nz  = 8'd4;
    vecs[0].col = {8'd0,8'd1,8'd2,8'd3, 96'd0};
    vecs[0].val = {8'd5,8'd5,8'd5,8'd5, 96'd0};
    // all zero
    vecs[1].m   = '0;
    vecs[1].rp  = '0;
    vecs[1].nz  = 8'd0;
    vecs[1].col = '0;
    vecs[1].val = '0;
    // fully dense 1..16
    vecs[2].m   = {8'd1,8'd2,8'd3,8'd4, 8'd5,8'd6,8'd7,8'd8, 8'd9,8'd10,8'd11,8'd12, 8'd13,8'd14,8'd15,8'd16};
    vecs[2].rp  = {8'd0,8'd4,8'd8,8'd12,8'd16};
    vecs[2].nz  = 8'd16;
    vecs[2].col = {4{8'd0,8'd1,8'd2,8'd3}};
    vecs[2].val = {8'd1,8'd2,8'd3,8'd4, 8'd5,8'd6,8'd7,8'd8, 8'd9,8'd10,8'd11,8'd12, 8'd13,8'd14,8'd15,8'd16};
    // mixed, with an all-zero row in the middle
    vecs[3].m   = {8'd0,8'd7,8'd0,8'd3, 32'd0, 8'd9,8'd0,8'd0,8'd0, 8'd0,8'd0,8'd2,8'd1};
    vecs[3].rp  = {8'd0,8'd2,8'd2,8'd3,8'd5};
    vecs[3].nz  = 8'd5;
    vecs[3].col = {8'd1,8'd3,8'd0,8'd2,8'd3, 88'd0};
    vecs[3].val = {8'd7,8'd3,8'd9,8'd2,8'd1, 88'd0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Table-driven 4x4 runs, no input gaps.
    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      build_expected(4);
      run_matrix(16, 22, 1'b0, 1'b0);
      compare_writes($sformatf("vec%0d", v));
    end

    // Mixed vector with random gaps and a value base that wraps past 2^32.
    mb = 32'hFFFF_FFFE;
    load_vec(3);
    build_expected(4);
    run_matrix(16, 22, 1'b1, 1'b0);
    compare_writes("vec3_gaps_wrap");
    mb = 32'd90;

    // Dense run with start pulsed mid-matrix and in the done cycle.
    load_vec(2);
    build_expected(4);
    run_matrix(16, 22, 1'b0, 1'b1);
    compare_writes("start_while_busy");

    // Default 16x16: row 0 skips col 4 and 15, row 1 skips col 12.
    sel = 1'b1;
    for (int j = 0; j < 256; j++) mat[j] = '0;
    exp_nz = 0;
    for (int c = 0; c < 15; c++) if (c != 4) begin
      mat[c] = DW'(100 + c);
      exp_col[exp_nz] = DW'(c); exp_val[exp_nz] = DW'(100 + c); exp_nz++;
    end
    for (int c = 0; c < 16; c++) if (c != 12) begin
      mat[16 + c] = DW'(200 + c);
      exp_col[exp_nz] = DW'(c); exp_val[exp_nz] = DW'(200 + c); exp_nz++;
    end
    exp_rp[0] = 0; exp_rp[1] = 14;
    for (int r = 2; r < 17; r++) exp_rp[r] = 29;
    build_expected(16);
    run_matrix(256, 274, 1'b0, 1'b0);
    compare_writes("m16");
    build_expected(16);
    run_matrix(256, 274, 1'b1, 1'b0);
    compare_writes("m16_gaps");
    sel = 1'b0;

    // Reset in the middle of row 2, then a clean identity run.
    load_vec(2);
    @(posedge clk);
    #1;
    start_d = 1'b1;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    feed(10, 1'b0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    check_reset_outputs("abort_held");
    rst_n = 1'b1;
    act1_q.delete();
    act2_q.delete();
    load_vec(0);
    build_expected(4);
    run_matrix(16, 22, 1'b0, 1'b0);
    compare_writes("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog: a hang is reported as a failure, then the run stops.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
